// File: rtl/gao_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// gao_capture_ctrl_if
//   Bundles the control, probe, RAM-write and status signals of the capture
//   sequencer so that the sequencer and whoever drives it share one port.
//
//   Handshake: there is no valid/ready pair on this bus. arm and abort are
//   single-cycle request pulses sampled on the rising clock edge; abort has
//   priority over arm. mem_we qualifies mem_waddr/mem_wdata on every cycle it
//   is high; the RAM is always ready and never back-pressures.
//
//   Modports
//     master : drives arm, abort, probe, trig_mask, trig_value, pre_len;
//              observes RAM-write and status outputs.
//     slave  : the sequencer itself (mirror of master).
//   state_dbg exposes the sequencer state encoding
//   (0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE).
// ---------------------------------------------------------------------------
interface gao_capture_ctrl_if #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 4
);
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] probe;
  logic [DATA_W-1:0] trig_mask;
  logic [DATA_W-1:0] trig_value;
  logic [ADDR_W-1:0] pre_len;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              triggered;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [2:0]        state_dbg;

  modport master (
    output arm, abort, probe, trig_mask, trig_value, pre_len,
    input  mem_we, mem_waddr, mem_wdata, busy, triggered, done,
           trig_addr, start_addr, state_dbg
  );

  modport slave (
    input  arm, abort, probe, trig_mask, trig_value, pre_len,
    output mem_we, mem_waddr, mem_wdata, busy, triggered, done,
           trig_addr, start_addr, state_dbg
  );
endinterface

// File: rtl/gao_capture_ctrl.sv
// ---------------------------------------------------------------------------
// gao_capture_ctrl
//   Trigger/capture sequencer for the on-chip probe bus. On arm it records
//   pre_len pre-trigger samples into a DEPTH-entry circular RAM, keeps
//   writing until the masked trigger compare matches, then fills the rest of
//   the RAM so that exactly DEPTH samples around the trigger are retained.
//   trig_addr / start_addr tell the readout where the trigger sample and the
//   oldest valid sample live.
//
//   Ports
//     clk, rst  : single clock, synchronous active-high reset
//     bus       : gao_capture_ctrl_if.slave
//                 in : arm, abort, probe, trig_mask, trig_value, pre_len
//                 out: mem_we, mem_waddr, mem_wdata, busy, triggered, done,
//                      trig_addr, start_addr, state_dbg
// ---------------------------------------------------------------------------
module gao_capture_ctrl #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  gao_capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST = '1;  // DEPTH-1

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] probe_q;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [DATA_W-1:0] mask_l;
  logic [DATA_W-1:0] value_l;
  logic [ADDR_W-1:0] pre_len_l;
  logic              active;     // PRE/WAIT/POST: RAM is being written
  logic              done;
  logic              triggered;
  logic              match;

  // Compare is made on the sample being written this cycle (probe_q).
  assign match = ((probe_q ^ value_l) & mask_l) == '0;

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.arm) state_nxt = (bus.pre_len == '0) ? S_WAIT : S_PRE;
        end
        S_PRE: begin
          if (pre_cnt + ONE == pre_len_l) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          // No post-trigger writes remain when pre_len fills all but one slot.
          if (match) state_nxt = (pre_len_l == LAST) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (post_cnt == ONE) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      probe_q    <= '0;
      mem_waddr  <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      mask_l     <= '0;
      value_l    <= '0;
      pre_len_l  <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      probe_q <= bus.probe;
      state   <= state_nxt;
      active  <= (state_nxt == S_PRE) || (state_nxt == S_WAIT) || (state_nxt == S_POST);
      done    <= (state_nxt == S_DONE);

      if (bus.abort) begin
        // trig_addr/start_addr deliberately survive an abort.
        triggered <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (bus.arm) begin
              mem_waddr <= '0;
              pre_cnt   <= '0;
              triggered <= 1'b0;
              mask_l    <= bus.trig_mask;
              value_l   <= bus.trig_value;
              pre_len_l <= bus.pre_len;
            end
          end
          S_PRE: begin
            mem_waddr <= mem_waddr + ONE;
            pre_cnt   <= pre_cnt + ONE;
          end
          S_WAIT: begin
            mem_waddr <= mem_waddr + ONE;
            if (match) begin
              trig_addr  <= mem_waddr;
              start_addr <= mem_waddr - pre_len_l;  // wraps mod DEPTH
              triggered  <= 1'b1;
              post_cnt   <= LAST - pre_len_l;
            end
          end
          S_POST: begin
            mem_waddr <= mem_waddr + ONE;
            post_cnt  <= post_cnt - ONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_we     = active;
  assign bus.busy       = active;
  assign bus.mem_waddr  = mem_waddr;
  assign bus.mem_wdata  = probe_q;
  assign bus.done       = done;
  assign bus.triggered  = triggered;
  assign bus.trig_addr  = trig_addr;
  assign bus.start_addr = start_addr;
  assign bus.state_dbg  = state;

endmodule
